imem_loader: RTL



---
 rtl/imem_loader_if.sv | 35 +++
 rtl/imem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// ----------------------------------------------------------------------------
// imem_loader_if
//   Signal bundle between the program-image loader, the host byte link and the
//   CPU wrapper's IMEM reload port.
//
//   rx_vld        byte valid from the host link
//   rx_rdy        loader ready; a byte moves when rx_vld && rx_rdy
//   rx_dat[7:0]   byte data
//   imem_cpu_rstn CPU reset, active-low
//   imem_we       IMEM write strobe, one cycle per word
//   imem_waddr    IMEM word address (byte address bits [31:2])
//   imem_wdat     IMEM write data
//
//   modport master : the loader (it drives the IMEM write port and rx_rdy)
//   modport slave  : the environment (byte source and IMEM/CPU side)
// ----------------------------------------------------------------------------
interface imem_loader_if;
    logic        rx_vld;
    logic        rx_rdy;
    logic [7:0]  rx_dat;
    logic        imem_cpu_rstn;
    logic        imem_we;
    logic [29:0] imem_waddr;
    logic [31:0] imem_wdat;

    modport master (
        input  rx_vld, rx_dat,
        output rx_rdy, imem_cpu_rstn, imem_we, imem_waddr, imem_wdat
    );

    modport slave (
        output rx_vld, rx_dat,
        input  rx_rdy, imem_cpu_rstn, imem_we, imem_waddr, imem_wdat
    );
endinterface

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//   Parses a framed program image from a byte stream and reloads IMEM:
//     0x5A | CNT_L | CNT_H | N x 4 data bytes (little-endian words) | CSUM
//   CSUM is the XOR of all data bytes. The CPU is held in reset from the start
//   of a frame and released only after a frame whose checksum matches.
//
//   Ports
//     clk, srst   clock and synchronous active-high reset
//     bus         imem_loader_if.master (byte input, IMEM write port, CPU reset)
//     busy        frame in progress
//     done        one-cycle pulse after a good load
//     err_len     sticky: word count 0 or above NUM_WORDS_IMEM
//     err_csum    sticky: checksum mismatch
//     err_tmo     sticky: inter-byte timeout (0 when the feature is compiled out)
//
//   Optional feature: define IMEM_LOADER_TIMEOUT_EN to abort a frame after
//   TIMEOUT_CYCLES clocks without an accepted byte.
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int unsigned NUM_WORDS_IMEM = 8192,
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter bit          BOOT_HOLD      = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          srst,
    imem_loader_if.master bus,
    output logic          busy,
    output logic          done,
    output logic          err_len,
    output logic          err_csum,
    output logic          err_tmo
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_CHECK
    } state_e;

    localparam logic [7:0]  MAGIC     = 8'h5A;
    localparam logic [31:0] MAX_WORDS = 32'(NUM_WORDS_IMEM);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;            // word count N
    logic [15:0] word_idx_q, word_idx_d;  // words written so far
    logic [1:0]  byte_idx_q, byte_idx_d;  // byte position inside current word
    logic [31:0] word_q, word_d;
    logic [7:0]  xor_q, xor_d;
    logic [7:0]  csum_q, csum_d;
    logic        cpu_rstn_q, cpu_rstn_d;
    logic        we_q, we_d;
    logic [29:0] waddr_q, waddr_d;
    logic [31:0] wdat_q, wdat_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_len_q, err_len_d;
    logic        err_csum_q, err_csum_d;

    logic        rx_rdy;
    logic        accept;
    logic        frame_start;
    logic [15:0] cnt_full;
    logic        len_bad;
    logic        tmo_hit;

    assign rx_rdy      = (state_q != S_CHECK);
    assign accept      = bus.rx_vld && rx_rdy;
    assign frame_start = (state_q == S_IDLE) && accept && (bus.rx_dat == MAGIC);
    assign cnt_full    = {bus.rx_dat, cnt_q[7:0]};
    assign len_bad     = (cnt_full == 16'd0) || ({16'd0, cnt_full} > MAX_WORDS);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        xor_d      = xor_q;
        csum_d     = csum_q;
        cpu_rstn_d = cpu_rstn_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdat_d     = wdat_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_len_d  = err_len_q;
        err_csum_d = err_csum_q;

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_LEN0;
                    cpu_rstn_d = 1'b0;
                    busy_d     = 1'b1;
                    err_len_d  = 1'b0;
                    err_csum_d = 1'b0;
                    xor_d      = 8'h00;
                    word_idx_d = 16'd0;
                    byte_idx_d = 2'd0;  // drop any partial word left by a timeout
                end
            end
            S_LEN0: begin
                if (accept) begin
                    cnt_d   = {8'h00, bus.rx_dat};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    cnt_d = cnt_full;
                    if (len_bad) begin
                        err_len_d = 1'b1;
                        busy_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    // Shift right so the first byte of a word ends up in [7:0].
                    word_d     = {bus.rx_dat, word_q[31:8]};
                    xor_d      = xor_q ^ bus.rx_dat;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        we_d       = 1'b1;
                        wdat_d     = word_d;
                        waddr_d    = ADDR_BASE[31:2] + 30'(word_idx_q);
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_d == cnt_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    csum_d  = bus.rx_dat;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                if (csum_q == xor_q) begin
                    cpu_rstn_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    err_csum_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort leaves the CPU held and never writes the partial word.
        if (tmo_hit) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of the others.
        if (srst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            xor_q      <= '0;
            csum_q     <= '0;
            cpu_rstn_q <= ~BOOT_HOLD;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdat_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_len_q  <= 1'b0;
            err_csum_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
            csum_q     <= csum_d;
            cpu_rstn_q <= cpu_rstn_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdat_q     <= wdat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_len_q  <= err_len_d;
            err_csum_q <= err_csum_d;
        end
    end

`ifdef IMEM_LOADER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        err_tmo_q, err_tmo_d;

    // Counts clocks since the last accepted byte while a frame is open.
    assign tmo_hit = (state_q != S_IDLE) && !accept && (tmo_cnt_q == TMO_LAST);

    always_comb begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
        if ((state_q == S_IDLE) || accept || tmo_hit) begin
            tmo_cnt_d = 32'd0;
        end
        err_tmo_d = err_tmo_q;
        if (tmo_hit) begin
            err_tmo_d = 1'b1;
        end else if (frame_start) begin
            err_tmo_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            tmo_cnt_q <= '0;
            err_tmo_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_tmo_q <= err_tmo_d;
        end
    end

    assign err_tmo = err_tmo_q;
`else
    logic [31:0] unused_tmo;
    assign unused_tmo = 32'(TIMEOUT_CYCLES);
    assign tmo_hit    = 1'b0;
    assign err_tmo    = 1'b0;
`endif

    assign bus.rx_rdy        = rx_rdy;
    assign bus.imem_cpu_rstn = cpu_rstn_q;
    assign bus.imem_we       = we_q;
    assign bus.imem_waddr    = waddr_q;
    assign bus.imem_wdat     = wdat_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err_len           = err_len_q;
    assign err_csum          = err_csum_q;

endmodule
